controller_bus_port: RTL and testbench

- CPU-side front end for the two NES controller ports at $4016/$4017. It sits between the 6502 bus fabric and the controller shift-register block.
- Decodes CPU accesses to the ports. Latches the strobe bit from writes to $4016 and issues one shift pulse per read of each port.
- Returns read data that merges the controller block's driven bits with open-bus bits.

---
 rtl/nes_io_pkg.sv | 17 +
 rtl/bus_access_detect.sv | 23 ++
 rtl/controller_bus_port.sv | 92 +++++++++
 tb/tb_controller_bus_port.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/nes_io_pkg.sv
// Shared definitions for the NES I/O front end: controller port addresses,
// the driven-bit mask type and the open-bus merge helper.
package nes_io_pkg;

   localparam logic [15:0] CTRL_PORT_A_ADDR = 16'h4016;
   localparam logic [15:0] CTRL_PORT_B_ADDR = 16'h4017;

   typedef logic [7:0] ctrl_mask_t;

   // Driven bits come from the controller, undriven bits float at the last bus value.
   function automatic logic [7:0] open_bus_merge(input logic [7:0] value,
                                                 input ctrl_mask_t active,
                                                 input logic [7:0] bus);
      return (value & active) | (bus & ~active);
   endfunction

endpackage

// File: rtl/bus_access_detect.sv
// Turns a multi-cycle CPU access level into a single start pulse.
// Resets to "busy" so an access already in progress at reset release is ignored.
module bus_access_detect (
   input  logic clock,
   input  logic reset,
   input  logic cpu_access,
   output logic start
);

   logic access_q_r;

   // Track the previous cycle's access level.
   always_ff @(posedge clock) begin
      if (reset) begin
         access_q_r <= 1'b1;
      end else begin
         access_q_r <= cpu_access;
      end
   end

   assign start = cpu_access & ~access_q_r;

endmodule

// File: rtl/controller_bus_port.sv
// CPU-side decode for the $4016/$4017 controller ports: strobe latch,
// per-read shift pulses and open-bus merged read data.
module controller_bus_port
   import nes_io_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_access,
   input  logic        cpu_rw,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic [7:0]  ctrl_lower_reg,
   input  logic [7:0]  ctrl_lower_reg_active,
   input  logic [7:0]  ctrl_upper_reg,
   input  logic [7:0]  ctrl_upper_reg_active,
   output logic        strobe,
   output logic [1:0]  shift,
   output logic [7:0]  read_data,
   output logic        read_sel
);

   logic       start_s;
   logic [7:0] merged_a_s;
   logic [7:0] merged_b_s;
   logic       strobe_r;
   logic [1:0] shift_r;
   logic [7:0] read_data_r;
   logic       read_sel_r;
   logic [7:0] open_bus_r;

   bus_access_detect u_detect (
      .clock      (clock),
      .reset      (reset),
      .cpu_access (cpu_access),
      .start      (start_s)
   );

   // Candidate read values for each port against the current open-bus value.
   always_comb begin
      merged_a_s = open_bus_merge(ctrl_lower_reg, ctrl_lower_reg_active, open_bus_r);
      merged_b_s = open_bus_merge(ctrl_upper_reg, ctrl_upper_reg_active, open_bus_r);
   end

   // Register one event per access start; shift self-clears after one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         strobe_r    <= 1'b0;
         shift_r     <= 2'b00;
         read_data_r <= 8'h00;
         read_sel_r  <= 1'b0;
         open_bus_r  <= 8'h00;
      end else begin
         shift_r <= 2'b00;
         if (!cpu_access) begin
            read_sel_r <= 1'b0;
         end else begin
            read_sel_r <= read_sel_r;
         end
         if (start_s) begin
            if (!cpu_rw) begin
               open_bus_r <= cpu_wdata;
               if (cpu_addr == CTRL_PORT_A_ADDR) begin
                  strobe_r <= cpu_wdata[0];
               end else begin
                  strobe_r <= strobe_r;
               end
            end else if (cpu_addr == CTRL_PORT_A_ADDR) begin
               read_data_r <= merged_a_s;
               open_bus_r  <= merged_a_s;
               shift_r     <= 2'b01;
               read_sel_r  <= 1'b1;
            end else if (cpu_addr == CTRL_PORT_B_ADDR) begin
               read_data_r <= merged_b_s;
               open_bus_r  <= merged_b_s;
               shift_r     <= 2'b10;
               read_sel_r  <= 1'b1;
            end else begin
               // Reads elsewhere are another device's business; leave state alone.
               open_bus_r <= open_bus_r;
            end
         end else begin
            strobe_r <= strobe_r;
         end
      end
   end

   assign strobe    = strobe_r;
   assign shift     = shift_r;
   assign read_data = read_data_r;
   assign read_sel  = read_sel_r;

endmodule

// File: tb/tb_controller_bus_port.sv
// Directed bench for controller_bus_port with hand-computed expectations.
module tb_controller_bus_port;

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_access;
   logic        cpu_rw;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  ctrl_lower_reg;
   logic [7:0]  ctrl_lower_reg_active;
   logic [7:0]  ctrl_upper_reg;
   logic [7:0]  ctrl_upper_reg_active;
   logic        strobe;
   logic [1:0]  shift;
   logic [7:0]  read_data;
   logic        read_sel;

   int pass_count = 0;
   int total_count = 0;

   controller_bus_port dut (
      .clock                 (clock),
      .reset                 (reset),
      .cpu_access            (cpu_access),
      .cpu_rw                (cpu_rw),
      .cpu_addr              (cpu_addr),
      .cpu_wdata             (cpu_wdata),
      .ctrl_lower_reg        (ctrl_lower_reg),
      .ctrl_lower_reg_active (ctrl_lower_reg_active),
      .ctrl_upper_reg        (ctrl_upper_reg),
      .ctrl_upper_reg_active (ctrl_upper_reg_active),
      .strobe                (strobe),
      .shift                 (shift),
      .read_data             (read_data),
      .read_sel              (read_sel)
   );

   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total_count++;
      assert (obs === exp) pass_count++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Start an access; the first cycle ends just after its start edge.
   task automatic begin_access(input logic rw, input logic [15:0] addr, input logic [7:0] wdata);
      cpu_rw     = rw;
      cpu_addr   = addr;
      cpu_wdata  = wdata;
      cpu_access = 1'b1;
      cyc();
   endtask

   task automatic end_access();
      cpu_access = 1'b0;
      cyc();
   endtask

   initial begin
      reset = 1'b1;
      cpu_access = 1'b0;
      cpu_rw = 1'b0;
      cpu_addr = 16'h0000;
      cpu_wdata = 8'h00;
      ctrl_lower_reg = 8'h00;
      ctrl_lower_reg_active = 8'h00;
      ctrl_upper_reg = 8'h00;
      ctrl_upper_reg_active = 8'h00;
      cyc();
      cyc();
      chk("rst_strobe", {7'd0, strobe}, 8'h00);
      chk("rst_shift", {6'd0, shift}, 8'h00);
      chk("rst_rdata", read_data, 8'h00);
      chk("rst_rsel", {7'd0, read_sel}, 8'h00);
      reset = 1'b0;
      cyc();

      // Strobe set then cleared
      begin_access(1'b0, 16'h4016, 8'h01);
      chk("wr1_strobe", {7'd0, strobe}, 8'h01);
      chk("wr1_shift", {6'd0, shift}, 8'h00);
      end_access();
      begin_access(1'b0, 16'h4016, 8'h00);
      chk("wr0_strobe", {7'd0, strobe}, 8'h00);
      chk("wr0_shift", {6'd0, shift}, 8'h00);
      end_access();

      // Seed open bus with 8'h40 from an unrelated write
      begin_access(1'b0, 16'h0000, 8'h40);
      chk("wr_other_strobe", {7'd0, strobe}, 8'h00);
      end_access();

      // Eight single-cycle reads of port A
      ctrl_lower_reg = 8'h01;
      ctrl_lower_reg_active = 8'h01;
      for (int i = 0; i < 8; i++) begin
         begin_access(1'b1, 16'h4016, 8'h00);
         chk("rdA_data", read_data, 8'h41);
         chk("rdA_shift", {6'd0, shift}, 8'h01);
         chk("rdA_rsel", {7'd0, read_sel}, 8'h01);
         end_access();
         chk("rdA_shift_off", {6'd0, shift}, 8'h00);
         chk("rdA_rsel_off", {7'd0, read_sel}, 8'h00);
      end

      // Three-cycle read of port B: 05 | (41 & F0) = 45
      ctrl_upper_reg = 8'hA5;
      ctrl_upper_reg_active = 8'h0F;
      begin_access(1'b1, 16'h4017, 8'h00);
      chk("rdB_data", read_data, 8'h45);
      chk("rdB_shift_c1", {6'd0, shift}, 8'h02);
      chk("rdB_rsel_c1", {7'd0, read_sel}, 8'h01);
      cyc();
      chk("rdB_shift_c2", {6'd0, shift}, 8'h00);
      chk("rdB_rsel_c2", {7'd0, read_sel}, 8'h01);
      cyc();
      chk("rdB_shift_c3", {6'd0, shift}, 8'h00);
      chk("rdB_rsel_c3", {7'd0, read_sel}, 8'h01);
      end_access();
      chk("rdB_rsel_off", {7'd0, read_sel}, 8'h00);
      chk("rdB_data_hold", read_data, 8'h45);

      // Write to $4017 leaves strobe alone but sets open bus to FF
      begin_access(1'b0, 16'h4017, 8'hFF);
      chk("wrB_strobe", {7'd0, strobe}, 8'h00);
      chk("wrB_shift", {6'd0, shift}, 8'h00);
      end_access();
      ctrl_lower_reg = 8'h02;
      ctrl_lower_reg_active = 8'h07;
      begin_access(1'b1, 16'h4016, 8'h00);
      chk("rdA_openbus", read_data, 8'hFA);
      end_access();

      // Access held across reset release produces nothing
      cpu_rw = 1'b1;
      cpu_addr = 16'h4016;
      cpu_access = 1'b1;
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      cyc();
      chk("rstacc_shift", {6'd0, shift}, 8'h00);
      chk("rstacc_rsel", {7'd0, read_sel}, 8'h00);
      cyc();
      chk("rstacc_shift2", {6'd0, shift}, 8'h00);
      chk("rstacc_rdata", read_data, 8'h00);
      end_access();
      begin_access(1'b1, 16'h4016, 8'h00);
      chk("post_rst_shift", {6'd0, shift}, 8'h01);
      chk("post_rst_data", read_data, 8'h02);
      chk("post_rst_rsel", {7'd0, read_sel}, 8'h01);
      end_access();

      // Alternating port reads with one idle cycle between
      ctrl_upper_reg = 8'h80;
      ctrl_upper_reg_active = 8'h80;
      begin_access(1'b1, 16'h4016, 8'h00);
      chk("alt1_shift", {6'd0, shift}, 8'h01);
      chk("alt1_data", read_data, 8'h02);
      end_access();
      chk("alt1_idle", {6'd0, shift}, 8'h00);
      begin_access(1'b1, 16'h4017, 8'h00);
      chk("alt2_shift", {6'd0, shift}, 8'h02);
      chk("alt2_data", read_data, 8'h82);
      end_access();
      chk("alt2_idle", {6'd0, shift}, 8'h00);
      begin_access(1'b1, 16'h4016, 8'h00);
      chk("alt3_shift", {6'd0, shift}, 8'h01);
      chk("alt3_data", read_data, 8'h82);
      end_access();
      chk("alt3_idle", {6'd0, shift}, 8'h00);

      // Read of an unrelated address changes nothing
      begin_access(1'b1, 16'h2002, 8'h00);
      chk("other_rd_shift", {6'd0, shift}, 8'h00);
      chk("other_rd_rsel", {7'd0, read_sel}, 8'h00);
      chk("other_rd_data", read_data, 8'h82);
      end_access();

      $display("%0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule
